// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and byte-level helpers
// Purpose: state type, FSM encoding, round constants, GF(2^8) helpers,
//          S-box and FIPS <-> row-major state packing.
// Ports:   none (package).
package aes_pkg;

    typedef logic [127:0] state_t;

    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } fsm_t;

    // Indexed directly by round number; entry 0 and 11..15 are never used.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // FIPS byte i (bits [127-8i -: 8]) is s[r][c] with i = r + 4c;
    // internally s[r][c] lives at bits [32r+8c +: 8].
    function automatic state_t pack_fips(input state_t fips);
        state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[32*r + 8*c +: 8] = fips[127 - 8*(r + 4*c) -: 8];
        return s;
    endfunction

    function automatic state_t unpack_fips(input state_t s);
        state_t fips;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                fips[127 - 8*(r + 4*c) -: 8] = s[32*r + 8*c +: 8];
        return fips;
    endfunction

endpackage

// File: rtl/aes_enc_sequencer_if.sv
// rtl/aes_enc_sequencer_if.sv - plaintext/key in and ciphertext out handshake bundle
// Purpose: groups the input and output valid/ready channels of the sequencer.
// Ports:   in_valid/in_ready/in_data/in_key (block in),
//          out_valid/out_ready/out_data (ciphertext out).
//          master = issuing/consuming side, slave = sequencer.
interface aes_enc_sequencer_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_data;
    state_t in_key;
    logic   out_valid;
    logic   out_ready;
    state_t out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one AES-128 key-expansion step
// Purpose: next round key from current round key and round constant.
// Ports:   key (current round key, FIPS order), rcon (round constant),
//          key_next (next round key, FIPS order).
module aes_key_step
    import aes_pkg::*;
(
    input  state_t     key,
    input  logic [7:0] rcon,
    output state_t     key_next
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;

    // SubWord(RotWord(w3)) with the rotation folded into the byte order.
    assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon, 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_next = {n0, n1, n2, n3};
endmodule

// File: rtl/mix_columns.sv
// rtl/mix_columns.sv - per-column GF(2^8) matrix multiply of the state
// Purpose: MixColumns on the row-major internal state.
// Ports:   din (state in), dout (mixed state).
module mix_columns
    import aes_pkg::*;
(
    input  state_t din,
    output state_t dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[     8*c +: 8];
        assign a1 = din[32 + 8*c +: 8];
        assign a2 = din[64 + 8*c +: 8];
        assign a3 = din[96 + 8*c +: 8];
        // Rows of {02 03 01 01} circulant; 03*x written as xtime(x)^x.
        assign dout[     8*c +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign dout[32 + 8*c +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign dout[64 + 8*c +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign dout[96 + 8*c +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
endmodule

// File: rtl/shift_rows.sv
// rtl/shift_rows.sv - cyclic left rotation of state row r by r bytes
// Purpose: ShiftRows on the row-major internal state.
// Ports:   din (state in), dout (shifted state).
module shift_rows
    import aes_pkg::*;
(
    input  state_t din,
    output state_t dout
);
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign dout[32*r + 8*c +: 8] = din[32*r + 8*((c + r) % 4) +: 8];
        end
    end
endmodule

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - byte-wise S-box substitution of the round state
// Purpose: applies the AES S-box to all 16 state bytes (layout-agnostic).
// Ports:   din (state in), dout (substituted state).
module sub_bytes
    import aes_pkg::*;
(
    input  state_t din,
    output state_t dout
);
    for (genvar i = 0; i < 16; i++) begin : g_sb
        assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end
endmodule

// File: rtl/aes_enc_sequencer.sv
// rtl/aes_enc_sequencer.sv - iterative AES-128 encryption sequencer
// Purpose: runs the shared round datapath over one state register with
//          on-the-fly key expansion; one block in flight at a time.
// Ports:   clk, rst (sync, active-high), bus (slave side of the
//          in/out handshake bundle), busy (ROUND or FINAL),
//          round_idx (current round, debug).
module aes_enc_sequencer
    import aes_pkg::*;
#(
    parameter int NR           = NR_AES128,
    parameter int ROUND_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_enc_sequencer_if.slave    bus,
    output logic                  busy,
    output logic [3:0]            round_idx
);
    if (NR != NR_AES128) begin : g_bad_nr
        $error("aes_enc_sequencer: NR must be 10 (AES-128 only)");
    end
    if (ROUND_CYCLES != 1 && ROUND_CYCLES != 2) begin : g_bad_rc
        $error("aes_enc_sequencer: ROUND_CYCLES must be 1 or 2");
    end

    fsm_t       fsm_q, fsm_d;
    state_t     st_q, st_d;
    state_t     rk_q, rk_d;
    state_t     out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] round_idx_q, round_idx_d;
    logic       cyc_q, cyc_d;

    state_t     sb_out, sr_out, mc_out, key_next;
    logic       accept;
    logic       complete;

    sub_bytes    u_sub_bytes   (.din(st_q),   .dout(sb_out));
    shift_rows   u_shift_rows  (.din(sb_out), .dout(sr_out));
    mix_columns  u_mix_columns (.din(sr_out), .dout(mc_out));

    aes_key_step u_key_step (
        .key      (rk_q),
        .rcon     (RCON[round_idx_q]),
        .key_next (key_next)
    );

    // Accepting in DONE while the result is being taken gives back-to-back blocks.
    assign bus.in_ready = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // With two cycles per round, the first cycle only arms cyc_q.
    assign complete = (ROUND_CYCLES == 1) || cyc_q;

    always_comb begin
        fsm_d       = fsm_q;
        st_d        = st_q;
        rk_d        = rk_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        round_idx_d = round_idx_q;
        cyc_d       = cyc_q;

        case (fsm_q)
            ST_IDLE: ;
            ST_ROUND: begin
                cyc_d = ~complete;
                if (complete) begin
                    st_d        = mc_out ^ pack_fips(key_next);
                    rk_d        = key_next;
                    round_idx_d = round_idx_q + 4'd1;
                    if (round_idx_q == 4'(NR - 1)) fsm_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                cyc_d = ~complete;
                if (complete) begin
                    st_d        = sr_out ^ pack_fips(key_next);
                    rk_d        = key_next;
                    out_data_d  = unpack_fips(sr_out ^ pack_fips(key_next));
                    out_valid_d = 1'b1;
                    fsm_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        if (accept) begin
            st_d        = pack_fips(bus.in_data ^ bus.in_key);
            rk_d        = bus.in_key;
            round_idx_d = 4'd1;
            cyc_d       = 1'b0;
            fsm_d       = ST_ROUND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            round_idx_q <= 4'd0;
            cyc_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            round_idx_q <= round_idx_d;
            cyc_q       <= cyc_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);
    assign round_idx     = round_idx_q;
endmodule

// File: doc/aes_enc_sequencer.md
Name: aes_enc_sequencer

Overview:
Iterative AES-128 encryption controller that sequences the shared round datapath (sub_bytes, shift_rows, mix_columns, add-round-key) over one state register, with on-the-fly key expansion. It accepts a plaintext/key pair via valid/ready and returns the ciphertext via valid/ready. It sits between the ALU crypto-instruction issue logic and the combinational AES round modules.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is legal; any other value is an elaboration error.
ROUND_CYCLES, 1, clock cycles per round; 1 or 2. With 2, each round's result registers on the second cycle, giving a timing-closure option.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  plaintext and key presented
in_ready  out  1  sequencer can accept
in_data  in  128  plaintext, FIPS-197 byte order (byte0 = bits [127:120])
in_key  in  128  cipher key, FIPS-197 byte order
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts
out_data  out  128  ciphertext, FIPS-197 byte order
busy  out  1  high in ROUND or FINAL
round_idx  out  4  current round number (debug)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Internal state layout: row-major 4x4; byte s[r][c] at bits [32r+8c+7 : 32r+8c]. The FIPS byte at index r+4c maps to s[r][c]. Packing and unpacking happen only at the ports.
- FSM states: IDLE, ROUND, FINAL, DONE.
- Reset: FSM goes to IDLE. State register, round-key register, out_data, round_idx and the cycle counter all clear to 0. out_valid=0, busy=0, in_ready=1 on the first cycle after reset.
- Reset mid-operation: the block is abandoned with no output produced. The next cycle is IDLE.
- in_ready = (IDLE) or (DONE and out_ready). This allows back-to-back blocks with no bubble.
- Accept edge (in_valid & in_ready):
  - state <= pack(in_data) ^ pack(in_key)
  - rk <= in_key
  - round_idx <= 1
  - next state is ROUND
  - in_data and in_key are sampled only on this edge; later changes to the inputs are ignored.
- ROUND (round_idx 1..NR-1):
  - rk_next = key_step(rk, rcon[round_idx])
  - state <= mix_columns(shift_rows(sub_bytes(state))) ^ pack(rk_next)
  - rk <= rk_next and round_idx++ on the completing cycle
  - the round completes every cycle when ROUND_CYCLES=1, or every 2nd cycle when ROUND_CYCLES=2 (a 1-bit counter gates the update)
  - after round NR-1 completes, go to FINAL
- FINAL: state <= shift_rows(sub_bytes(state)) ^ pack(key_step(rk, rcon[NR])), with no mix_columns. On completion:
  - out_data <= unpack(new state)
  - out_valid <= 1
  - go to DONE
- Latency: with ROUND_CYCLES=1, out_valid rises 10 cycles after the accept edge. With ROUND_CYCLES=2 it rises 20 cycles after.
- DONE:
  - out_valid stays high and out_data is held stable until out_ready.
  - out_ready with no new input: go to IDLE and clear out_valid.
  - out_ready together with in_valid: accept the new block on the same edge, go to ROUND and clear out_valid.
- No backpressure on the datapath mid-block; in_ready=0 during ROUND and FINAL.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- key_step(w0..w3): t = SubWord(RotWord(w3)) ^ {rcon,00,00,00}; then w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.

Decomposition:
- aes_pkg holds:
  - state_t (logic [127:0])
  - the sbox function
  - the rcon constant array
  - pack_fips/unpack_fips functions
  - NR_AES128 = 10
  - the FSM enum
- Sub-module aes_key_step (combinational, 128-bit key + 8-bit rcon -> next round key), instantiated once.
- Existing sub_bytes, shift_rows and mix_columns are instantiated as the datapath.

Test Plan:
- FIPS-197 App. B: in_data=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c -> out_data=3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
- FIPS-197 App. C.1: in_data=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back: App. B then C.1 with out_ready=1 and in_valid held -> second accept on the same edge as the first output handshake; second result 10 cycles later; no bubble.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, busy=0; release -> single handshake, then IDLE.
- Reset at round_idx=5, then start App. B -> no out_valid from the aborted block; outputs 0 the cycle after reset; correct ciphertext for the new block.
- ROUND_CYCLES=2 with App. B vectors -> same ciphertext, out_valid 20 cycles after accept; in_data changes after accept have no effect.
